// File: rtl/input_debouncer_if.sv
// -----------------------------------------------------------------------------
// input_debouncer_if
// Groups the data-path signals of the input debouncer into one bundle.
//
// Signals:
//   ENABLE     1      1 = debounce counters advance, 0 = decisions frozen
//   RAW_IN     WIDTH  raw asynchronous inputs (switches/pins)
//   CLEAN_OUT  WIDTH  debounced, registered level per channel
//   RISE       WIDTH  one-cycle pulse on an accepted 0->1 transition
//   FALL       WIDTH  one-cycle pulse on an accepted 1->0 transition
//   CHANGED    1      OR of all RISE/FALL bits, same cycle as the pulses
//
// Modports:
//   master  drives ENABLE/RAW_IN and observes the conditioned outputs
//   slave   the debouncer itself
// -----------------------------------------------------------------------------
interface input_debouncer_if #(
  parameter int WIDTH = 4
);

  logic             ENABLE;
  logic [WIDTH-1:0] RAW_IN;
  logic [WIDTH-1:0] CLEAN_OUT;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic             CHANGED;

  modport master (
    output ENABLE,
    output RAW_IN,
    input  CLEAN_OUT,
    input  RISE,
    input  FALL,
    input  CHANGED
  );

  modport slave (
    input  ENABLE,
    input  RAW_IN,
    output CLEAN_OUT,
    output RISE,
    output FALL,
    output CHANGED
  );

endinterface

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Front-end conditioning stage for the downstream logic stage's IN1..IN4.
// Each raw input passes through a two-flop synchronizer and is then debounced
// by a per-channel stability counter. A new level is accepted only after the
// synchronized input has differed from the current clean level for
// STABLE_CYCLES enabled clock edges in a row; any return to the clean level
// restarts the count. Accepted transitions produce one-cycle RISE/FALL pulses
// and a combined CHANGED flag, all registered.
//
// Parameters:
//   WIDTH          number of independent channels
//   CNT_W          stability counter width (STABLE_CYCLES <= 2**CNT_W)
//   STABLE_CYCLES  enabled mismatch edges needed to accept a level (>= 1)
//
// Ports:
//   CLK   clock, all state updates on the rising edge
//   RST   synchronous reset, active-low
//   bus   slave side of input_debouncer_if (ENABLE, RAW_IN in;
//         CLEAN_OUT, RISE, FALL, CHANGED out)
// -----------------------------------------------------------------------------
module input_debouncer #(
  parameter int WIDTH         = 4,
  parameter int CNT_W         = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input_debouncer_if.slave    bus
);

  // Terminal count: reaching it on a further enabled mismatch accepts the level.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync1_d;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] sync2_d;
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             changed_q;
  logic             changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Next-state logic: synchronizer shift plus per-channel debounce decision.
  always_comb begin
    sync1_d = bus.RAW_IN;
    sync2_d = sync1_q;
    clean_d = clean_q;
    rise_d  = {WIDTH{1'b0}};
    fall_d  = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == clean_q[i]) begin
        // Input agrees with the accepted level: any partial progress is a
        // glitch and is discarded, whether or not counting is enabled.
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (!bus.ENABLE) begin
        // Frozen: hold the count so re-enabling resumes where it stopped.
        cnt_d[i] = cnt_q[i];
      end else if (cnt_q[i] >= LAST_CNT) begin
        // The >= also recovers a corrupted counter instead of letting it run
        // past the terminal value.
        clean_d[i] = sync2_q[i];
        cnt_d[i]   = {CNT_W{1'b0}};
        rise_d[i]  = sync2_q[i];
        fall_d[i]  = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q   <= {WIDTH{1'b0}};
      sync2_q   <= {WIDTH{1'b0}};
      clean_q   <= {WIDTH{1'b0}};
      rise_q    <= {WIDTH{1'b0}};
      fall_q    <= {WIDTH{1'b0}};
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.CLEAN_OUT = clean_q;
  assign bus.RISE      = rise_q;
  assign bus.FALL      = fall_q;
  assign bus.CHANGED   = changed_q;

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
// Drives directed scenarios followed by randomized input/enable/reset traffic.
// For every clock edge the driver computes the expected outputs with a
// reference model and pushes them into a queue; an independent monitor pops
// one entry after each edge and compares it with the DUT outputs.
//
// The model tracks, per channel, the list of enabled edges at which the
// synchronized input has disagreed with the clean level since the last
// agreement; the level is accepted once that list holds STABLE entries.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

  localparam int WIDTH  = 4;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  input_debouncer_if #(.WIDTH(WIDTH)) bus ();

  input_debouncer #(
    .WIDTH         (WIDTH),
    .CNT_W         (8),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_s1    = 4'b0000;  // raw sampled one edge ago
  logic [WIDTH-1:0] m_s2    = 4'b0000;  // raw sampled two edges ago
  logic [WIDTH-1:0] m_clean = 4'b0000;
  int               hits [WIDTH][$];    // edge numbers of enabled mismatches
  int               cyc = 0;

  // Apply one edge worth of stimulus, predict the outputs after that edge.
  task automatic step(input logic [WIDTH-1:0] raw, input logic en, input logic rstn);
    exp_t             e;
    logic [WIDTH-1:0] view;
    logic [WIDTH-1:0] old;
    bus.RAW_IN = raw;
    bus.ENABLE = en;
    rst        = rstn;
    cyc++;
    old = m_clean;
    if (!rstn) begin
      m_s1    = 4'b0000;
      m_s2    = 4'b0000;
      m_clean = 4'b0000;
      for (int i = 0; i < WIDTH; i++) hits[i].delete();
    end else begin
      view = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      for (int i = 0; i < WIDTH; i++) begin
        if (view[i] == m_clean[i]) begin
          hits[i].delete();
        end else if (en) begin
          hits[i].push_back(cyc);
          if (hits[i].size() == STABLE) begin
            m_clean[i] = view[i];
            hits[i].delete();
          end
        end
      end
    end
    if (!rstn) begin
      e.rise = 4'b0000;
      e.fall = 4'b0000;
    end else begin
      e.rise = m_clean & ~old;
      e.fall = ~m_clean & old;
    end
    e.clean   = m_clean;
    e.changed = |(e.rise | e.fall);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [WIDTH-1:0] raw, input logic en, input int n);
    for (int k = 0; k < n; k++) step(raw, en, 1'b1);
  endtask

  // Monitor: one comparison per clock edge, sampled 1 time unit after it.
  initial begin : monitor
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.CLEAN_OUT, bus.RISE, bus.FALL, bus.CHANGED};
        tests++;
        if (act !== e) begin
          fails++;
          $display("FAIL outputs t=%0t: got clean=%b rise=%b fall=%b chg=%b, want clean=%b rise=%b fall=%b chg=%b",
                   $time, act.clean, act.rise, act.fall, act.changed,
                   e.clean, e.rise, e.fall, e.changed);
        end
      end
    end
  end

  initial begin : driver
    logic [WIDTH-1:0] raw;
    int               p;
    bus.RAW_IN = 4'b0000;
    bus.ENABLE = 1'b1;

    // 1: reset with all inputs high, then release and let them be accepted.
    repeat (3) step(4'hF, 1'b1, 1'b0);
    hold(4'hF, 1'b1, 8);
    hold(4'h0, 1'b1, 8);

    // 2: clean step on channel 0.
    hold(4'b0001, 1'b1, 7);

    // 3: bounces on channel 1 that must be rejected, then a steady high.
    hold(4'b0011, 1'b1, 3);
    hold(4'b0001, 1'b1, 6);
    hold(4'b0011, 1'b1, 2);
    hold(4'b0001, 1'b1, 1);
    hold(4'b0011, 1'b1, 8);

    // 4: channel 2 mismatch frozen by ENABLE=0 mid-count, then resumed.
    hold(4'b0111, 1'b1, 4);
    hold(4'b0111, 1'b0, 10);
    hold(4'b0111, 1'b1, 4);

    // 5: reset while channel 3 is counting, released with the input still high.
    hold(4'b1111, 1'b1, 4);
    repeat (2) step(4'b1111, 1'b1, 1'b0);
    hold(4'b1111, 1'b1, 8);

    // 6: simultaneous fall and rise on two channels.
    hold(4'b1000, 1'b1, 8);
    hold(4'b0100, 1'b1, 8);

    // Randomized traffic with varying bounce density.
    raw = 4'b0100;
    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(2))
        0:       p = 2;
        1:       p = 8;
        default: p = 32;
      endcase
      for (int k = 0; k < 50; k++) begin
        for (int b = 0; b < WIDTH; b++) begin
          if ($urandom_range(p - 1) == 0) raw[b] = ~raw[b];
        end
        step(raw, ($urandom_range(9) != 0), ($urandom_range(199) != 0));
      end
    end

    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
